// File: rtl/gate_bist_pkg.sv
// Shared types and constants for the 2-input gate BIST checker.
package gate_bist_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        APPLY  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int NUM_VECTORS = 4;

    // Truth tables indexed by {A,B}.
    localparam logic [3:0] OR_TT  = 4'b1110;
    localparam logic [3:0] AND_TT = 4'b1000;
    localparam logic [3:0] XOR_TT = 4'b0110;

endpackage

// File: rtl/gate_bist_checker.sv
// Sweeps all four input vectors of a 2-input gate, waits a settle time per
// vector, and compares the gate response against an expected truth table.
module gate_bist_checker
    import gate_bist_pkg::*;
#(
    parameter logic [3:0] EXPECTED      = OR_TT,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a_out,
    output logic       b_out,
    input  logic       y_in,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);
    localparam logic [1:0] LAST_VEC    = 2'(NUM_VECTORS - 1);

    state_t     state_q, state_d;
    logic [1:0] vidx_q, vidx_d;
    logic [3:0] settle_q, settle_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic       pass_q, pass_d;
    logic [2:0] err_q, err_d;
    logic [3:0] fail_q, fail_d;

    always_comb begin
        state_d  = state_q;
        vidx_d   = vidx_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        pass_d   = pass_q;
        err_d    = err_q;
        fail_d   = fail_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = APPLY;
                    vidx_d  = 2'd0;
                    err_d   = 3'd0;
                    fail_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end
            APPLY: begin
                a_d      = vidx_q[1];
                b_d      = vidx_q[0];
                settle_d = SETTLE_INIT;
                state_d  = SETTLE;
            end
            SETTLE: begin
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                if (y_in != EXPECTED[vidx_q]) begin
                    if (err_q < 3'd4) begin
                        err_d = err_q + 3'd1;
                    end
                    fail_d[vidx_q] = 1'b1;
                end
                // pass is settled on entry to DONE so it is valid alongside the done pulse
                if (vidx_q == LAST_VEC) begin
                    vidx_d  = 2'd0;
                    pass_d  = (err_d == 3'd0);
                    state_d = DONE;
                end else begin
                    vidx_d  = vidx_q + 2'd1;
                    state_d = APPLY;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            vidx_q   <= 2'd0;
            settle_q <= 4'd0;
            a_q      <= 1'b0;
            b_q      <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= 3'd0;
            fail_q   <= 4'd0;
        end else begin
            state_q  <= state_d;
            vidx_q   <= vidx_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
        end
    end

    assign a_out     = a_q;
    assign b_out     = b_q;
    assign busy      = (state_q == APPLY) || (state_q == SETTLE) || (state_q == SAMPLE);
    assign done      = (state_q == DONE);
    assign pass      = pass_q;
    assign err_count = err_q;
    assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gate_bist_checker.sv
// Directed bench for gate_bist_checker: a scoreboard holds expected sweep
// results and vector order, popped when the DUT drives or completes a sweep.
module tb_gate_bist_checker;
    import gate_bist_pkg::*;

    typedef struct {
        logic [2:0] err;
        logic [3:0] fail;
        logic       pass;
        int         done_cyc;
    } result_t;

    logic clk;
    logic rst_n;

    // DUT 0: default parameters, selectable gate model
    logic       start0, a0, b0, y0, busy0, done0, pass0;
    logic [2:0] err0;
    logic [3:0] fail0;
    // DUT 1: SETTLE_CYCLES=1; DUT 2: SETTLE_CYCLES=15; both see an OR gate
    logic       start1, a1, b1, y1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [3:0] fail1;
    logic       start2, a2, b2, y2, busy2, done2, pass2;
    logic [2:0] err2;
    logic [3:0] fail2;

    int mode;   // 0 OR, 1 AND, 2 stuck-0, 3 stuck-1
    int sel;
    int tests;
    int fails;

    result_t    sb[$];
    logic [1:0] vq[$];

    logic       sel_a, sel_b, sel_busy, sel_done, sel_pass;
    logic [2:0] sel_err;
    logic [3:0] sel_fail;

    function automatic logic ymodel(input int m, input logic a, input logic b);
        case (m)
            0:       return a | b;
            1:       return a & b;
            2:       return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    assign y0 = ymodel(mode, a0, b0);
    assign y1 = a1 | b1;
    assign y2 = a2 | b2;

    gate_bist_checker u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .a_out(a0), .b_out(b0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fail0)
    );

    gate_bist_checker #(.EXPECTED(OR_TT), .SETTLE_CYCLES(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a_out(a1), .b_out(b1), .y_in(y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fail1)
    );

    gate_bist_checker #(.EXPECTED(OR_TT), .SETTLE_CYCLES(15)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a_out(a2), .b_out(b2), .y_in(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fail2)
    );

    always_comb begin
        sel_a = a0; sel_b = b0; sel_busy = busy0; sel_done = done0;
        sel_pass = pass0; sel_err = err0; sel_fail = fail0;
        if (sel == 1) begin
            sel_a = a1; sel_b = b1; sel_busy = busy1; sel_done = done1;
            sel_pass = pass1; sel_err = err1; sel_fail = fail1;
        end else if (sel == 2) begin
            sel_a = a2; sel_b = b2; sel_busy = busy2; sel_done = done2;
            sel_pass = pass2; sel_err = err2; sel_fail = fail2;
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_start(input int s, input logic v);
        case (s)
            0:       start0 = v;
            1:       start1 = v;
            default: start2 = v;
        endcase
    endtask

    // One sweep on DUT s; extra=1 also pulses start at busy cycle 5 and in DONE.
    task automatic run_sweep(input int s, input int settle, input logic [2:0] e_err,
                             input logic [3:0] e_fail, input bit extra);
        int         busy_len;
        int         done_c;
        int         n_done;
        result_t    r;
        logic [1:0] v;
        busy_len   = 4 * (settle + 2);
        sel        = s;
        r.err      = e_err;
        r.fail     = e_fail;
        r.pass     = (e_err == 3'd0);
        r.done_cyc = busy_len + 1;
        sb.push_back(r);
        for (int k = 0; k < 4; k++) vq.push_back(2'(k));
        drive_start(s, 1'b1);
        step();
        drive_start(s, 1'b0);
        done_c = 0;
        n_done = 0;
        for (int c = 1; c <= busy_len + 8; c++) begin
            if (c == 1) begin
                check("busy_first", sel_busy, 1);
                check("err_cleared", sel_err, 0);
                check("fail_cleared", sel_fail, 0);
            end
            if (c >= 2 && c <= busy_len && ((c - 2) % (settle + 2)) == 0 && vq.size() > 0) begin
                v = vq.pop_front();
                check("vector_ab", {sel_a, sel_b}, v);
            end
            if (sel_done) begin
                n_done++;
                if (done_c == 0 && sb.size() > 0) begin
                    done_c = c;
                    r = sb.pop_front();
                    check("done_cycle", c, r.done_cyc);
                    check("busy_in_done", sel_busy, 0);
                    check("pass", sel_pass, r.pass);
                    check("err_count", sel_err, r.err);
                    check("fail_vec", sel_fail, r.fail);
                end
            end
            drive_start(s, extra && (c == 5 || sel_done));
            step();
        end
        drive_start(s, 1'b0);
        check("done_pulses", n_done, 1);
        check("idle_after", sel_busy, 0);
        check("hold_err", sel_err, e_err);
        sb.delete();
        vq.delete();
    endtask

    initial begin
        int n_done;
        tests  = 0;
        fails  = 0;
        sel    = 0;
        mode   = 0;
        start0 = 1'b0;
        start1 = 1'b0;
        start2 = 1'b0;
        rst_n  = 1'b0;
        step();
        step();
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_pass", pass0, 0);
        check("rst_err", err0, 0);
        check("rst_fail", fail0, 0);
        check("rst_ab", {a0, b0}, 0);

        // Start is accepted on the very first cycle out of reset
        rst_n = 1'b1;
        mode  = 0;
        run_sweep(0, 2, 3'd0, 4'b0000, 1'b0);
        mode = 1;
        run_sweep(0, 2, 3'd2, 4'b0110, 1'b0);
        mode = 2;
        run_sweep(0, 2, 3'd3, 4'b1110, 1'b0);
        mode = 3;
        run_sweep(0, 2, 3'd1, 4'b0001, 1'b0);
        mode = 0;
        run_sweep(0, 2, 3'd0, 4'b0000, 1'b1);
        run_sweep(0, 2, 3'd0, 4'b0000, 1'b0);

        run_sweep(1, 1, 3'd0, 4'b0000, 1'b0);
        run_sweep(2, 15, 3'd0, 4'b0000, 1'b0);

        // Reset during SETTLE of vector 2 (busy cycle 10)
        sel  = 0;
        mode = 2;
        drive_start(0, 1'b1);
        step();
        drive_start(0, 1'b0);
        repeat (9) step();
        check("pre_abort_busy", busy0, 1);
        check("pre_abort_err", err0, 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("abort_busy", busy0, 0);
        check("abort_err", err0, 0);
        check("abort_fail", fail0, 0);
        check("abort_pass", pass0, 0);
        check("abort_ab", {a0, b0}, 0);
        n_done = 0;
        for (int c = 0; c < 40; c++) begin
            if (done0) n_done++;
            step();
        end
        check("abort_no_done", n_done, 0);
        check("abort_idle", busy0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
